mult_col_acc: RTL and testbench
===============================

Name: mult_col_acc

Overview:
- Consumer-side partner of the pipelined 128x128 multiplier.
- Accepts the split product stream (carry = high word, ret = low word) and accumulates it column-by-column in product-scanning order.
- Emits the finished multi-word result one W-bit word per column, least significant first, with a final flush of the high words.
- Sits between the multiplier output and the IDDMM word memory / reduction stage.

Parameters:
- W, 128, word width; product is 2W (hi = carry, lo = ret).
- GUARD, 8, extra accumulator bits; supports up to 2^GUARD products per column without overflow.
- FLUSH_WORDS, 2, words emitted after the frame's last column (ceil((W+GUARD)/W)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_lo  in  W  product low word (multiplier ret).
- in_hi  in  W  product high word (multiplier carry).
- in_col_last  in  1  beat is the last product of the current column.
- in_frame_last  in  1  beat closes the last column of the operation; valid only with in_col_last.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  W  result word.
- out_last  out  1  final word of the frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, flush count=0, out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0.
- Accumulator acc has width 2W+GUARD. P = {in_hi, in_lo}, zero-extended.
- States:
  - IDLE: in_ready=0. Next cycle go to ACC; acc already 0. IDLE lasts exactly one cycle after reset or after a frame.
  - ACC:
    - in_ready = !out_valid || out_ready (single output register; a word is consumed and refilled in the same cycle).
    - Beat with in_col_last=0: acc <= acc + P. No output.
    - Beat with in_col_last=1: out_data <= (acc+P)[W-1:0]; out_valid <= 1; acc <= (acc+P) >> W (logical). Sum is computed at full 2W+GUARD width before the shift.
    - If in_frame_last is also 1: go to FLUSH with count = FLUSH_WORDS.
  - FLUSH:
    - in_ready=0.
    - Whenever the output register is free or being accepted: out_data <= acc[W-1:0]; acc <= acc >> W; count decrements.
    - On the word where count reaches 1, out_last <= 1.
    - After that word is accepted (out_valid && out_ready && out_last): acc=0, go to IDLE.
- Latency: one cycle from accepted in_col_last beat to out_valid.
- out_data and out_last are held stable while out_valid && !out_ready.
- Boundary and illegal cases:
  - Single-beat column (in_col_last=1 on the first beat) is legal and uses acc+P.
  - in_frame_last without in_col_last: treated as in_col_last=1.
  - More than 2^GUARD beats in one column: undefined. The bench must not generate it.
  - in_valid while in_ready=0: beat ignored; upstream holds it.
  - Back-to-back column-close beats with out_ready=1: one word per cycle, no bubbles.
  - Reset asserted mid-frame: all state and partial sums discarded immediately; out_valid drops asynchronously.
- All arithmetic is unsigned. No saturation. Carry out of 2W+GUARD is impossible within the GUARD limit.

Decomposition:
- Shared package: W, GUARD, ACC_W = 2W+GUARD, state encoding constants (IDLE, ACC, FLUSH), FLUSH_WORDS.
- One natural sub-module, mult_col_acc_out: the output holding register with its valid/ready logic (load, hold, last flag).
- Accumulator datapath and FSM stay in the top module.

Test Plan:
- Single product, frame of one column: P = 0x1 hi, 0x2 lo, col_last=frame_last=1 -> words 0x2, 0x1, 0x0 (last), then IDLE.
- Two-beat column overflow: two beats of hi=lo=all-ones, then a one-beat last column with P=0.
  - Word0 = 0xFFFF...FFFE.
  - Word1 = 0xFFFF...FFFF (the 0x1 carry from lo plus hi).
  - Flush words 0x1, 0x0, the latter with out_last.
- Backpressure: hold out_ready=0 for 5 cycles after the first column word.
  - in_ready stays 0 and out_data is stable.
  - The next column beat is accepted in the same cycle out_ready rises.
- Streaming check: 4x4-word operands driven as product-scanning beats from the multiplier (x=0x58e2fccefa7e3061367f1d57a4e7455a-based operands) -> 8+2 output words match the reference 512-bit product plus zero guard words; no bubbles with out_ready=1.
- Reset mid-frame: assert rst_n=0 after the 3rd beat -> out_valid=0 and busy=0 at once; a following single-product frame gives a clean result with no residue.
- Column of 256 beats of P = 2^256-1 -> correct words, with GUARD bits carrying into the flush words.

Source files
------------

// File: rtl/mult_col_acc_pkg.sv
// Shared constants and state encoding for the product-scanning column accumulator.
// W           : word width; each product beat is 2W bits (hi = carry, lo = ret).
// GUARD       : extra accumulator bits, allowing up to 2^GUARD products per column.
// ACC_W       : accumulator width, 2W + GUARD.
// FLUSH_WORDS : words emitted after the frame's last column, ceil((W+GUARD)/W).
package mult_col_acc_pkg;

  localparam int unsigned W           = 128;
  localparam int unsigned GUARD       = 8;
  localparam int unsigned ACC_W       = 2 * W + GUARD;
  localparam int unsigned FLUSH_WORDS = 2;
  localparam int unsigned CNT_W       = $clog2(FLUSH_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage : mult_col_acc_pkg

// File: rtl/mult_col_acc_if.sv
// Product-beat input stream and result-word output stream of mult_col_acc.
// Input side : in_valid/in_ready handshake carrying in_lo, in_hi, in_col_last, in_frame_last.
// Output side: out_valid/out_ready handshake carrying out_data, out_last.
// master = producer/consumer environment, slave = the accumulator.
interface mult_col_acc_if;
  import mult_col_acc_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_lo;
  logic [W-1:0] in_hi;
  logic         in_col_last;
  logic         in_frame_last;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_lo, in_hi, in_col_last, in_frame_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_lo, in_hi, in_col_last, in_frame_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface : mult_col_acc_if

// File: rtl/mult_col_acc_out.sv
// Single-entry output holding register with valid/ready handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i/last_i (only asserted while free_c is high)
//   data_i     : word to present downstream
//   last_i     : word closes the frame
//   ready_i    : downstream accepts the presented word
//   valid_o    : word presented
//   data_o     : presented word, stable while valid_o && !ready_i
//   last_o     : presented word is the frame's last
//   free_c     : register empty or being drained this cycle (combinational)
module mult_col_acc_out
  import mult_col_acc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         free_c
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;
  logic         last_q,  last_d;

  // Consume and refill in the same cycle to sustain one word per cycle.
  assign free_c  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

  // Load has priority; otherwise an accepted word empties the register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule : mult_col_acc_out

// File: rtl/mult_col_acc.sv
// Column-by-column accumulator for the split product stream of the 128x128 multiplier.
// Each column's products are summed at ACC_W width; the column close emits the low word
// and shifts the sum right by W so the remainder carries into the next column. After the
// frame's last column the remaining high words are flushed, the last one tagged out_last.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mult_col_acc_if (product beats in, result words out)
//   busy  : state != IDLE
module mult_col_acc
  import mult_col_acc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mult_col_acc_if.slave  bus,
  output logic           busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_d;

  logic [ACC_W-1:0]   sum_c;
  logic               close_c;
  logic               fire_c;
  logic               last_taken_c;
  logic               out_free_c;
  logic               load_c;
  logic [W-1:0]       load_data_c;
  logic               load_last_c;

  // Full-width sum so the column carry survives the shift.
  assign sum_c        = acc_q + ACC_W'({bus.in_hi, bus.in_lo});
  // A frame-closing beat always closes its column too.
  assign close_c      = bus.in_col_last | bus.in_frame_last;
  assign bus.in_ready = (state_q == ST_ACC) & out_free_c;
  assign fire_c       = bus.in_valid & bus.in_ready;
  assign last_taken_c = bus.out_valid & bus.out_ready & bus.out_last;

  // Next-state, accumulator update and output-register load request.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    load_c      = 1'b0;
    load_data_c = '0;
    load_last_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (fire_c) begin
          if (close_c) begin
            load_c      = 1'b1;
            load_data_c = sum_c[W-1:0];
            acc_d       = sum_c >> W;
            if (bus.in_frame_last) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_W'(FLUSH_WORDS);
            end
          end else begin
            acc_d = sum_c;
          end
        end
      end
      ST_FLUSH: begin
        if (last_taken_c) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end else if (out_free_c && (cnt_q != '0)) begin
          load_c      = 1'b1;
          load_data_c = acc_q[W-1:0];
          load_last_c = (cnt_q == CNT_W'(1));
          acc_d       = acc_q >> W;
          cnt_d       = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, accumulator, flush counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
    end
  end

  // Result word holding register.
  mult_col_acc_out u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_c),
    .data_i  (load_data_c),
    .last_i  (load_last_c),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_data),
    .last_o  (bus.out_last),
    .free_c  (out_free_c)
  );

endmodule : mult_col_acc

// File: tb/tb_mult_col_acc.sv
// Testbench for mult_col_acc: randomized product streams against a whole-number model
// (the frame result is the sum of every product weighted by 2^(W*column)).
module tb_mult_col_acc;
  import mult_col_acc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mult_col_acc_if bus ();

  mult_col_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int unsigned cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         cl;
    logic         fl;
  } tb_beat_t;

  tb_beat_t     beats[$];
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  int unsigned  got_cyc[$];

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Frame value = sum of products, each shifted by W times its column index.
  task automatic model(output logic [2047:0] t, output int nw);
    int col;
    col = 0;
    t   = '0;
    foreach (beats[i]) begin
      t = t + (2048'({beats[i].hi, beats[i].lo}) << (W * col));
      if (beats[i].cl || beats[i].fl) col++;
    end
    nw = col + FLUSH_WORDS;
  endtask

  task automatic drive_beats(input int vld_pct);
    bit taken;
    int g;
    foreach (beats[i]) begin
      taken = 1'b0;
      g     = 0;
      while (!taken && g < 5000) begin
        @(negedge clk);
        g++;
        bus.in_valid      = ($urandom_range(99) < vld_pct);
        bus.in_hi         = beats[i].hi;
        bus.in_lo         = beats[i].lo;
        bus.in_col_last   = beats[i].cl;
        bus.in_frame_last = beats[i].fl;
        #1 taken = bus.in_valid && bus.in_ready;
      end
      if (!taken) begin
        total_cnt++;
        bad_cnt++;
        $display("FAIL drive_timeout beat=%0d accepted=0 required=1", i);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic sink_words(input int rdy_pct, input int nw);
    int g;
    g = 0;
    while (got_data.size() < nw && g < 20000) begin
      @(negedge clk);
      g++;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        got_cyc.push_back(cyc);
      end
    end
    total_cnt++;
    if (got_data.size() != nw) begin
      bad_cnt++;
      $display("FAIL sink_timeout words=%0d required=%0d", got_data.size(), nw);
    end
  endtask

  task automatic run_frame(input int rdy_pct, input int vld_pct, input int nw);
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    fork
      drive_beats(vld_pct);
      sink_words(rdy_pct, nw);
    join
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) begin bad_cnt++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total_cnt++; if (bus.out_data !== '0) begin bad_cnt++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    total_cnt++; if (bus.out_last !== 1'b0) begin bad_cnt++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
    total_cnt++; if (bus.in_ready !== 1'b0) begin bad_cnt++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin bad_cnt++; $display("FAIL idle_cycle busy=%b in_ready=%b exp=0/0", busy, bus.in_ready); end
    @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin bad_cnt++; $display("FAIL acc_entry busy=%b in_ready=%b exp=1/1", busy, bus.in_ready); end
  endtask

  task automatic test_single();
    logic [2047:0] t;
    int nw;
    beats.delete();
    beats.push_back('{hi: W'(1), lo: W'(2), cl: 1'b1, fl: 1'b1});
    model(t, nw);
    run_frame(100, 100, nw);
    for (int k = 0; k < nw; k++) begin
      total_cnt++;
      if (k >= got_data.size()) begin bad_cnt++; $display("FAIL single_missing k=%0d", k); end
      else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == nw - 1)) begin
        bad_cnt++; $display("FAIL single_word k=%0d got=%h/%b exp=%h/%b", k, got_data[k], got_last[k], t[W*k +: W], k == nw - 1);
      end
    end
    @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL single_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    logic [2047:0] t;
    int nw;
    beats.delete();
    beats.push_back('{hi: '1, lo: '1, cl: 1'b0, fl: 1'b0});
    beats.push_back('{hi: '1, lo: '1, cl: 1'b1, fl: 1'b0});
    beats.push_back('{hi: '0, lo: '0, cl: 1'b1, fl: 1'b1});
    model(t, nw);
    run_frame(70, 80, nw);
    for (int k = 0; k < nw; k++) begin
      total_cnt++;
      if (k >= got_data.size()) begin bad_cnt++; $display("FAIL ovf_missing k=%0d", k); end
      else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == nw - 1)) begin
        bad_cnt++; $display("FAIL ovf_word k=%0d got=%h/%b exp=%h/%b", k, got_data[k], got_last[k], t[W*k +: W], k == nw - 1);
      end
    end
    @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL ovf_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ah, al, bh, bl;
    logic [2047:0] t;
    bit taken;
    int g;
    ah = rnd_word(); al = rnd_word(); bh = rnd_word(); bl = rnd_word();
    t  = 2048'({ah, al}) + (2048'({bh, bl}) << W);
    taken = 1'b0;
    g     = 0;
    while (!taken && g < 50) begin
      @(negedge clk);
      g++;
      bus.out_ready     = 1'b0;
      bus.in_valid      = 1'b1;
      bus.in_hi         = ah;
      bus.in_lo         = al;
      bus.in_col_last   = 1'b1;
      bus.in_frame_last = 1'b0;
      #1 taken = bus.in_ready;
    end
    total_cnt++; if (!taken) begin bad_cnt++; $display("FAIL bp_first_accept got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid      = 1'b1;
      bus.in_hi         = bh;
      bus.in_lo         = bl;
      bus.in_col_last   = 1'b1;
      bus.in_frame_last = 1'b1;
      #1;
      total_cnt++; if (bus.in_ready !== 1'b0) begin bad_cnt++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== al) begin bad_cnt++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, al); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) begin bad_cnt++; $display("FAIL bp_release in_ready=%b exp=1", bus.in_ready); end
    got_data.delete();
    got_last.delete();
    g = 0;
    while (got_data.size() < 3 && g < 30) begin
      @(negedge clk);
      g++;
      bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
      end
    end
    for (int k = 1; k < 4; k++) begin
      total_cnt++;
      if (k - 1 >= got_data.size()) begin bad_cnt++; $display("FAIL bp_missing k=%0d", k); end
      else if (got_data[k-1] !== t[W*k +: W] || got_last[k-1] !== (k == 3)) begin
        bad_cnt++; $display("FAIL bp_word k=%0d got=%h/%b exp=%h/%b", k, got_data[k-1], got_last[k-1], t[W*k +: W], k == 3);
      end
    end
    @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL bp_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [2047:0] t;
    int nw;
    beats.delete();
    for (int c = 0; c < 6; c++)
      beats.push_back('{hi: rnd_word(), lo: rnd_word(), cl: 1'b1, fl: (c == 5)});
    model(t, nw);
    run_frame(100, 100, nw);
    for (int k = 0; k < nw; k++) begin
      total_cnt++;
      if (k >= got_data.size()) begin bad_cnt++; $display("FAIL b2b_missing k=%0d", k); end
      else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == nw - 1) || got_cyc[k] != got_cyc[0] + k) begin
        bad_cnt++; $display("FAIL b2b_word k=%0d got=%h/%b@%0d exp=%h/%b@%0d", k, got_data[k], got_last[k], got_cyc[k], t[W*k +: W], k == nw - 1, got_cyc[0] + k);
      end
    end
    @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL b2b_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_stream();
    logic [W-1:0] xw[4], yw[4];
    logic [2*W-1:0] p;
    logic [2047:0] t;
    int lo_i, hi_i;
    for (int pass = 0; pass < 2; pass++) begin
      xw[0] = W'(128'h58e2fccefa7e3061367f1d57a4e7455a);
      for (int i = 1; i < 4; i++) xw[i] = xw[0] ^ rnd_word();
      for (int i = 0; i < 4; i++) yw[i] = rnd_word();
      t = 2048'({xw[3], xw[2], xw[1], xw[0]}) * 2048'({yw[3], yw[2], yw[1], yw[0]});
      beats.delete();
      for (int c = 0; c < 7; c++) begin
        lo_i = (c > 3) ? c - 3 : 0;
        hi_i = (c < 3) ? c : 3;
        for (int i = lo_i; i <= hi_i; i++) begin
          p = (2*W)'(xw[i]) * (2*W)'(yw[c - i]);
          beats.push_back('{hi: p[2*W-1:W], lo: p[W-1:0], cl: (i == hi_i), fl: 1'b0});
        end
      end
      beats.push_back('{hi: '0, lo: '0, cl: 1'b1, fl: 1'b1});
      if (pass == 0) run_frame(100, 100, 10);
      else           run_frame(50, 70, 10);
      for (int k = 0; k < 10; k++) begin
        total_cnt++;
        if (k >= got_data.size()) begin bad_cnt++; $display("FAIL stream_missing pass=%0d k=%0d", pass, k); end
        else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == 9)) begin
          bad_cnt++; $display("FAIL stream_word pass=%0d k=%0d got=%h/%b exp=%h/%b", pass, k, got_data[k], got_last[k], t[W*k +: W], k == 9);
        end
      end
      if (pass == 0) begin
        total_cnt++;
        if (got_cyc.size() != 10 || got_cyc[8] != got_cyc[7] + 1 || got_cyc[9] != got_cyc[7] + 2) begin
          bad_cnt++; $display("FAIL stream_bubble words=%0d exp consecutive tail", got_cyc.size());
        end
      end
      @(posedge clk);
      #1;
      total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL stream_idle pass=%0d busy=%b exp=0", pass, busy); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2047:0] t;
    int nw;
    bus.out_ready = 1'b0;
    beats.delete();
    beats.push_back('{hi: rnd_word(), lo: rnd_word(), cl: 1'b0, fl: 1'b0});
    beats.push_back('{hi: rnd_word(), lo: rnd_word(), cl: 1'b0, fl: 1'b0});
    beats.push_back('{hi: rnd_word(), lo: rnd_word(), cl: 1'b1, fl: 1'b0});
    drive_beats(100);
    total_cnt++; if (bus.out_valid !== 1'b1) begin bad_cnt++; $display("FAIL mid_pre_valid got=%b exp=1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) begin bad_cnt++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
    total_cnt++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin bad_cnt++; $display("FAIL mid_rst_busy busy=%b in_ready=%b exp=0/0", busy, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    beats.delete();
    beats.push_back('{hi: rnd_word(), lo: rnd_word(), cl: 1'b1, fl: 1'b1});
    model(t, nw);
    run_frame(100, 100, nw);
    for (int k = 0; k < nw; k++) begin
      total_cnt++;
      if (k >= got_data.size()) begin bad_cnt++; $display("FAIL mid_missing k=%0d", k); end
      else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == nw - 1)) begin
        bad_cnt++; $display("FAIL mid_word k=%0d got=%h/%b exp=%h/%b", k, got_data[k], got_last[k], t[W*k +: W], k == nw - 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_guard();
    logic [2047:0] t;
    int nw;
    beats.delete();
    for (int i = 0; i < 256; i++)
      beats.push_back('{hi: '1, lo: '1, cl: (i == 255), fl: (i == 255)});
    model(t, nw);
    run_frame(100, 100, nw);
    for (int k = 0; k < nw; k++) begin
      total_cnt++;
      if (k >= got_data.size()) begin bad_cnt++; $display("FAIL guard_missing k=%0d", k); end
      else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == nw - 1)) begin
        bad_cnt++; $display("FAIL guard_word k=%0d got=%h/%b exp=%h/%b", k, got_data[k], got_last[k], t[W*k +: W], k == nw - 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [2047:0] t;
    int nw, ncol, nb;
    tb_beat_t bt;
    for (int f = 0; f < 4; f++) begin
      ncol = $urandom_range(4, 1);
      beats.delete();
      for (int c = 0; c < ncol; c++) begin
        nb = $urandom_range(5, 1);
        for (int b = 0; b < nb; b++) begin
          bt.hi = ($urandom_range(3) == 0) ? '1 : rnd_word();
          bt.lo = ($urandom_range(3) == 0) ? '1 : rnd_word();
          bt.cl = (b == nb - 1);
          bt.fl = 1'b0;
          if (c == ncol - 1 && b == nb - 1) begin
            bt.fl = 1'b1;
            bt.cl = 1'($urandom_range(1));
          end
          beats.push_back(bt);
        end
      end
      model(t, nw);
      run_frame($urandom_range(100, 30), $urandom_range(100, 40), nw);
      for (int k = 0; k < nw; k++) begin
        total_cnt++;
        if (k >= got_data.size()) begin bad_cnt++; $display("FAIL rand_missing f=%0d k=%0d", f, k); end
        else if (got_data[k] !== t[W*k +: W] || got_last[k] !== (k == nw - 1)) begin
          bad_cnt++; $display("FAIL rand_word f=%0d k=%0d got=%h/%b exp=%h/%b", f, k, got_data[k], got_last[k], t[W*k +: W], k == nw - 1);
        end
      end
      @(posedge clk);
      #1;
      total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL rand_idle f=%0d busy=%b exp=0", f, busy); end
    end
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_lo         = '0;
    bus.in_hi         = '0;
    bus.in_col_last   = 1'b0;
    bus.in_frame_last = 1'b0;
    bus.out_ready     = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    test_guard();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t limit=1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_mult_col_acc
